// File: rtl/gat_bram_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gat_bram_load_ctrl
// Brief    : Multi-channel byte-to-word BRAM load controller with hardware
//            word counting, completion flags and sticky error detection.
// Revision : 1.0 - initial release
// ============================================================================
module gat_bram_load_ctrl #(
  parameter int NUM_CH = 3,
  parameter int BUS_W  = 32,
  parameter int DATA_W = 20,
  parameter int DEPTH  = 16384,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  input  logic [NUM_CH*CNT_W-1:0]    cfg_exp_cnt,
  input  logic [NUM_CH-1:0]          s_ena,
  input  logic [NUM_CH-1:0]          s_wea,
  input  logic [NUM_CH*(ADDR_W+2)-1:0] s_addra,
  input  logic [NUM_CH*BUS_W-1:0]    s_din,
  output logic [NUM_CH-1:0]          m_wr_en,
  output logic [NUM_CH*ADDR_W-1:0]   m_wr_addr,
  output logic [NUM_CH*DATA_W-1:0]   m_wr_data,
  output logic [NUM_CH-1:0]          ch_done,
  output logic                       all_done,
  output logic [NUM_CH-1:0]          err_unaligned,
  output logic [NUM_CH-1:0]          err_oob,
  output logic [NUM_CH-1:0]          err_late,
  output logic [NUM_CH*CNT_W-1:0]    dbg_cnt
);

  localparam int                c_ab    = ADDR_W + 2;
  localparam logic [ADDR_W:0]   c_depth = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, exp_q, exp_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic                eu_q, eu_d, eo_q, eo_d, el_q, el_d;

    logic [c_ab-1:0]     w_addr;
    logic [ADDR_W-1:0]   w_word;
    logic [DATA_W-1:0]   w_din;
    logic [CNT_W-1:0]    w_cfg_exp;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_req, w_aligned, w_inb, w_accept;

    assign w_addr    = s_addra[i*c_ab +: c_ab];
    assign w_word    = w_addr[c_ab-1:2];
    assign w_din     = s_din[i*BUS_W +: DATA_W];
    assign w_cfg_exp = cfg_exp_cnt[i*CNT_W +: CNT_W];
    assign w_cnt_inc = cnt_q + 1'b1;
    assign w_req     = s_ena[i] & s_wea[i];
    assign w_aligned = (w_addr[1:0] == 2'b00);
    assign w_inb     = ({1'b0, w_word} < c_depth);
    assign w_accept  = (state_q == ST_LOAD) & w_aligned & w_inb;

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      exp_d     = exp_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = done_q;
      eu_d      = eu_q;
      eo_d      = eo_q;
      el_d      = el_q;
      // Configuration has priority: a colliding write is silently dropped.
      if (cfg_valid) begin
        exp_d   = w_cfg_exp;
        cnt_d   = '0;
        eu_d    = 1'b0;
        eo_d    = 1'b0;
        el_d    = 1'b0;
        done_d  = (w_cfg_exp == '0);
        state_d = (w_cfg_exp == '0) ? ST_DONE : ST_LOAD;
      end else if (w_req) begin
        if (w_accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = w_word;
          wr_data_d = w_din;
          cnt_d     = w_cnt_inc;
          if (w_cnt_inc == exp_q) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          if (!w_aligned)           eu_d = 1'b1;
          if (!w_inb)               eo_d = 1'b1;
          if (state_q != ST_LOAD)   el_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        exp_q     <= '0;
        wr_en_q   <= 1'b0;
        wr_addr_q <= '0;
        wr_data_q <= '0;
        done_q    <= 1'b0;
        eu_q      <= 1'b0;
        eo_q      <= 1'b0;
        el_q      <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        exp_q     <= exp_d;
        wr_en_q   <= wr_en_d;
        wr_addr_q <= wr_addr_d;
        wr_data_q <= wr_data_d;
        done_q    <= done_d;
        eu_q      <= eu_d;
        eo_q      <= eo_d;
        el_q      <= el_d;
      end
    end

    assign m_wr_en[i]                     = wr_en_q;
    assign m_wr_addr[i*ADDR_W +: ADDR_W]  = wr_addr_q;
    assign m_wr_data[i*DATA_W +: DATA_W]  = wr_data_q;
    assign ch_done[i]                     = done_q;
    assign err_unaligned[i]               = eu_q;
    assign err_oob[i]                     = eo_q;
    assign err_late[i]                    = el_q;
    assign dbg_cnt[i*CNT_W +: CNT_W]      = cnt_q;
  end

  // Gated by cfg_valid so a re-arm drops all_done on the same edge as ch_done.
  logic all_done_q, all_done_d;

  always_comb begin
    all_done_d = ~cfg_valid & (&ch_done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      all_done_q <= 1'b0;
    end else begin
      all_done_q <= all_done_d;
    end
  end

  assign all_done = all_done_q;

endmodule
`default_nettype wire
